// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: latches jump/death/score pulses, arbitrates by priority
// (dead > score > jump) and plays each effect as a tick-paced half-period program.
module sfx_sequencer #(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned JUMP_HP     = 100000,
  parameter int unsigned JUMP_STEP   = 128,
  parameter int unsigned JUMP_TICKS  = 150,
  parameter int unsigned DEAD_HP     = 200000,
  parameter int unsigned DEAD_STEP   = 128,
  parameter int unsigned DEAD_TICKS  = 600,
  parameter int unsigned SCORE_HP1   = 56818,
  parameter int unsigned SCORE_HP2   = 42563,
  parameter int unsigned SCORE_TICKS = 80,
  parameter int unsigned GAP_TICKS   = 20,
  parameter int unsigned HP_MIN      = 1000
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        jump_evt,
  input  logic        dead_evt,
  input  logic        score_evt,
  input  logic        mute,
  output logic        tone_en,
  output logic [23:0] half_period,
  output logic [1:0]  active_id,
  output logic        busy
);
  // state | meaning
  // IDLE  | nothing playing, grant highest pending request
  // PLAY  | effect program running, tone enabled unless muted
  // GAP   | silent spacer after an effect
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = 16;

  localparam logic [1:0] ID_JUMP  = 2'd1;
  localparam logic [1:0] ID_SCORE = 2'd2;
  localparam logic [1:0] ID_DEAD  = 2'd3;

  localparam logic [PW-1:0] L_TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] L_JUMP_T    = CW'(JUMP_TICKS);
  localparam logic [CW-1:0] L_DEAD_T    = CW'(DEAD_TICKS);
  localparam logic [CW-1:0] L_SCORE_T1  = CW'(SCORE_TICKS);
  localparam logic [CW-1:0] L_SCORE_T2  = CW'(2 * SCORE_TICKS);
  localparam logic [CW-1:0] L_GAP_T     = CW'(GAP_TICKS);
  localparam logic [23:0]   L_JUMP_HP   = 24'(JUMP_HP);
  localparam logic [23:0]   L_JUMP_STEP = 24'(JUMP_STEP);
  localparam logic [23:0]   L_DEAD_HP   = 24'(DEAD_HP);
  localparam logic [23:0]   L_DEAD_STEP = 24'(DEAD_STEP);
  localparam logic [23:0]   L_SCORE_HP1 = 24'(SCORE_HP1);
  localparam logic [23:0]   L_SCORE_HP2 = 24'(SCORE_HP2);
  localparam logic [23:0]   L_HP_MIN    = 24'(HP_MIN);
  localparam logic [24:0]   L_JUMP_THR  = 25'(HP_MIN) + 25'(JUMP_STEP);
  localparam logic [23:0]   L_DEAD_THR  = 24'hFFFFFF - 24'(DEAD_STEP);

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_pend, w_pend_nxt, w_clr;
  logic [PW-1:0]   r_presc;
  logic [CW-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [23:0]     r_hp, w_hp_nxt;
  logic [1:0]      r_eff, w_eff_nxt;
  logic            w_tick, w_grant;
  logic [1:0]      w_grant_id;

  assign w_tick    = (r_presc == L_TICK_LAST);
  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hp_nxt    = r_hp;
    w_eff_nxt   = r_eff;
    w_grant     = 1'b0;
    w_grant_id  = 2'd0;
    w_clr       = 3'b000;
    case (r_state)
      S_IDLE: begin
        if (r_pend != 3'b000) begin
          w_grant    = 1'b1;
          w_grant_id = r_pend[2] ? ID_DEAD : (r_pend[1] ? ID_SCORE : ID_JUMP);
        end
      end
      S_PLAY: begin
        if (r_pend[2] && r_eff != ID_DEAD) begin
          w_grant    = 1'b1;
          w_grant_id = ID_DEAD;
        end else if (w_tick) begin
          w_cnt_nxt = w_cnt_inc;
          case (r_eff)
            ID_JUMP: begin
              w_hp_nxt = ({1'b0, r_hp} >= L_JUMP_THR) ? r_hp - L_JUMP_STEP : L_HP_MIN;
              if (w_cnt_inc == L_JUMP_T) w_state_nxt = S_GAP;
            end
            ID_DEAD: begin
              w_hp_nxt = (r_hp <= L_DEAD_THR) ? r_hp + L_DEAD_STEP : 24'hFFFFFF;
              if (w_cnt_inc == L_DEAD_T) w_state_nxt = S_GAP;
            end
            default: begin
              if (w_cnt_inc == L_SCORE_T1) w_hp_nxt = L_SCORE_HP2;
              if (w_cnt_inc == L_SCORE_T2) w_state_nxt = S_GAP;
            end
          endcase
          if (w_state_nxt == S_GAP) w_cnt_nxt = '0;
        end
      end
      S_GAP: begin
        if (r_pend[2] && r_eff != ID_DEAD) begin
          w_grant    = 1'b1;
          w_grant_id = ID_DEAD;
        end else if (w_tick) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == L_GAP_T) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_grant) begin
      w_state_nxt = S_PLAY;
      w_cnt_nxt   = '0;
      w_eff_nxt   = w_grant_id;
      case (w_grant_id)
        ID_DEAD:  begin w_hp_nxt = L_DEAD_HP;   w_clr = 3'b100; end
        ID_SCORE: begin w_hp_nxt = L_SCORE_HP1; w_clr = 3'b010; end
        default:  begin w_hp_nxt = L_JUMP_HP;   w_clr = 3'b001; end
      endcase
    end
  end

  // a pulse landing on its own grant edge survives the clear
  assign w_pend_nxt = (r_pend & ~w_clr) | {dead_evt, score_evt, jump_evt};

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pend  <= 3'b000;
      r_presc <= '0;
      r_cnt   <= '0;
      r_hp    <= 24'd0;
      r_eff   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_presc <= (w_grant || w_tick) ? '0 : r_presc + 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_hp    <= w_hp_nxt;
      r_eff   <= w_eff_nxt;
    end
  end

  assign tone_en     = (r_state == S_PLAY) && !mute;
  assign busy        = (r_state != S_IDLE);
  assign active_id   = (r_state == S_PLAY) ? r_eff : 2'd0;
  assign half_period = r_hp;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Self-checking bench for sfx_sequencer: effect timelines are predicted from
// grant times and closed-form per-effect pitch programs, then compared cycle by cycle.
module tb_sfx_sequencer;
  localparam int TD = 4, JT = 5, DT = 6, ST = 3, GT = 2;
  localparam int JHP = 1000, JS = 100, HMIN = 800;
  localparam int DHP = 200000, DS = 128, SH1 = 56818, SH2 = 42563;
  localparam int GAPC = GT * TD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_evt = 1'b0, dead_evt = 1'b0, score_evt = 1'b0, mute = 1'b0;
  logic        tone_en, busy;
  logic [23:0] half_period;
  logic [1:0]  active_id;

  int checks = 0;
  int errors = 0;
  int hp_prev = 0;

  sfx_sequencer #(
    .TICK_DIV(TD), .JUMP_HP(JHP), .JUMP_STEP(JS), .JUMP_TICKS(JT),
    .DEAD_HP(DHP), .DEAD_STEP(DS), .DEAD_TICKS(DT),
    .SCORE_HP1(SH1), .SCORE_HP2(SH2), .SCORE_TICKS(ST),
    .GAP_TICKS(GT), .HP_MIN(HMIN)
  ) dut (
    .CLK100MHZ(clk), .reset(rst), .jump_evt(jump_evt), .dead_evt(dead_evt),
    .score_evt(score_evt), .mute(mute), .tone_en(tone_en),
    .half_period(half_period), .active_id(active_id), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int ticks_of(input int e);
    return (e == 1) ? JT : (e == 2) ? 2 * ST : DT;
  endfunction

  function automatic int hp_at(input int e, input int k);
    longint v;
    if (e == 1) begin
      v = longint'(JHP) - longint'(k) * JS;
      if (v < HMIN) v = HMIN;
    end else if (e == 2) begin
      v = (k < ST) ? SH1 : SH2;
    end else begin
      v = longint'(DHP) + longint'(k) * DS;
      if (v > 64'hFFFFFF) v = 64'hFFFFFF;
    end
    return int'(v);
  endfunction

  // mask bits: 0 jump, 1 score, 2 dead; pre_at >= 1 injects a dead pulse at that edge
  task automatic run_scenario(input logic [2:0] mask, input int pre_at,
                              input bit rnd_mute, input bit mute_fix, input string name);
    int g_t[$], g_e[$], order[$];
    int t, total, idx, n, e, k;
    bit m;
    logic [27:0] exp_v, got_v;
    if (mask[2]) order.push_back(3);
    if (mask[1]) order.push_back(2);
    if (mask[0]) order.push_back(1);
    t = 1;
    foreach (order[i]) begin
      if (pre_at >= 1 && i == 1) t = pre_at + 1 + ticks_of(3) * TD + GAPC + 1;
      g_t.push_back(t);
      g_e.push_back(order[i]);
      t += ticks_of(order[i]) * TD + GAPC + 1;
      if (pre_at >= 1 && i == 0) begin
        g_t.push_back(pre_at + 1);
        g_e.push_back(3);
        t = pre_at + 1 + ticks_of(3) * TD + GAPC + 1;
      end
    end
    total = g_t[g_t.size()-1] + ticks_of(g_e[g_e.size()-1]) * TD + GAPC + 6;
    for (int cyc = 0; cyc <= total; cyc++) begin
      @(negedge clk);
      jump_evt  = (cyc == 0) && mask[0];
      score_evt = (cyc == 0) && mask[1];
      dead_evt  = ((cyc == 0) && mask[2]) || (cyc == pre_at);
      m = rnd_mute ? 1'($urandom_range(0, 1)) : mute_fix;
      mute = m;
      @(posedge clk);
      #1;
      idx = -1;
      foreach (g_t[i]) if (g_t[i] <= cyc) idx = i;
      if (idx < 0) begin
        exp_v = {1'b0, 1'b0, 2'd0, 24'(hp_prev)};
      end else begin
        n = cyc - g_t[idx];
        e = g_e[idx];
        if (n < ticks_of(e) * TD) begin
          k = n / TD;
          exp_v = {!m, 1'b1, 2'(e), 24'(hp_at(e, k))};
        end else begin
          exp_v = {1'b0, (n < ticks_of(e) * TD + GAPC), 2'd0, 24'(hp_at(e, ticks_of(e)))};
        end
      end
      got_v = {tone_en, busy, active_id, half_period};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s cyc %0d got tone=%0b busy=%0b id=%0d hp=%0d exp tone=%0b busy=%0b id=%0d hp=%0d",
                 name, cyc, got_v[27], got_v[26], got_v[25:24], got_v[23:0],
                 exp_v[27], exp_v[26], exp_v[25:24], exp_v[23:0]);
      end
    end
    e = g_e[g_e.size()-1];
    hp_prev = hp_at(e, ticks_of(e));
    jump_evt = 1'b0; score_evt = 1'b0; dead_evt = 1'b0; mute = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tone_en, busy, active_id, half_period} !== 28'd0) begin
      errors++;
      $display("FAIL reset got tone=%0b busy=%0b id=%0d hp=%0d exp all zero",
               tone_en, busy, active_id, half_period);
    end
    @(negedge clk);
    rst = 1'b0;
    hp_prev = 0;
  endtask

  task automatic test_jump();
    run_scenario(3'b001, -1, 1'b0, 1'b0, "jump");
  endtask

  task automatic test_score();
    run_scenario(3'b010, -1, 1'b0, 1'b0, "score");
  endtask

  task automatic test_simultaneous();
    run_scenario(3'b101, -1, 1'b0, 1'b0, "jump_dead_same_cycle");
    run_scenario(3'b111, -1, 1'b0, 1'b0, "all_three");
  endtask

  task automatic test_preempt();
    run_scenario(3'b001, 1 + 2 * TD, 1'b0, 1'b0, "dead_preempts_jump");
    run_scenario(3'b010, 1 + ST * 2 * TD + 3, 1'b0, 1'b0, "dead_preempts_score_gap");
  endtask

  task automatic test_mute();
    run_scenario(3'b010, -1, 1'b0, 1'b1, "mute_score");
  endtask

  task automatic test_random();
    logic [2:0] msk;
    int first, pre;
    for (int it = 0; it < 12; it++) begin
      msk = 3'($urandom_range(1, 7));
      first = msk[2] ? 3 : (msk[1] ? 2 : 1);
      pre = -1;
      if (!msk[2] && $urandom_range(0, 1) == 1)
        pre = 1 + $urandom_range(0, ticks_of(first) * TD + GAPC);
      run_scenario(msk, pre, 1'b1, 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    dead_evt = 1'b1;
    @(negedge clk);
    dead_evt = 1'b0;
    repeat (6) @(negedge clk);
    dead_evt = 1'b1;
    @(negedge clk);
    dead_evt = 1'b0;
    checks++;
    if (active_id !== 2'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_precondition got id=%0d busy=%0b exp id=3 busy=1", active_id, busy);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({tone_en, busy, active_id, half_period} !== 28'd0) begin
      errors++;
      $display("FAIL reset_mid_async got tone=%0b busy=%0b id=%0d hp=%0d exp all zero",
               tone_en, busy, active_id, half_period);
    end
    @(negedge clk);
    rst = 1'b0;
    hp_prev = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({tone_en, busy, active_id, half_period} !== 28'd0) begin
        errors++;
        $display("FAIL reset_mid_idle cyc %0d got tone=%0b busy=%0b id=%0d hp=%0d exp all zero",
                 c, tone_en, busy, active_id, half_period);
      end
    end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_score();
    test_simultaneous();
    test_preempt();
    test_mute();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
- Sound-effect controller that sits in front of the square-wave tone generator.
- Accepts one-cycle event pulses from game logic (jump, death, score), latches them as pending requests and arbitrates them by fixed priority.
- Plays each effect as a timed pitch program (sweep or two-note), driving the half-period and enable of the tone datapath.
- Runs entirely on the 100 MHz system clock. A 1 kHz tick prescaler paces all programs.

Parameters:
- TICK_DIV, 100000, system clocks per program tick (1 ms at 100 MHz)
- JUMP_HP, 100000, jump sweep starting half-period, in clocks
- JUMP_STEP, 128, half-period decrement per tick during jump (pitch rises)
- JUMP_TICKS, 150, jump duration in ticks
- DEAD_HP, 200000, death sweep starting half-period
- DEAD_STEP, 128, half-period increment per tick during death (pitch falls)
- DEAD_TICKS, 600, death duration in ticks
- SCORE_HP1, 56818, score first-note half-period
- SCORE_HP2, 42563, score second-note half-period
- SCORE_TICKS, 80, ticks per score note
- GAP_TICKS, 20, silent ticks between consecutive effects
- HP_MIN, 1000, lower saturation limit of the half-period

Ports:
- CLK100MHZ  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- jump_evt  in  1  one-cycle jump request pulse
- dead_evt  in  1  one-cycle death request pulse
- score_evt  in  1  one-cycle score request pulse
- mute  in  1  level; forces tone_en low, sequencing continues
- tone_en  out  1  tone generator enable
- half_period  out  24  tone half-period in clocks
- active_id  out  2  0 none, 1 jump, 2 score, 3 dead
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-high): state IDLE, tone_en=0, half_period=0, active_id=0, busy=0, all pending bits cleared, tick prescaler=0, tick counter=0. Reset asserted mid-effect silences output immediately, with no gap.
- Prescaler: counts 0..TICK_DIV-1 and pulses tick for one cycle at the wrap. It restarts at 0 on every grant, so the first program tick lands TICK_DIV cycles after the grant.
- Pending latches: an event pulse sets its pending bit in the same cycle. A grant clears that bit. An event arriving in the same cycle as its grant stays set.
- Priority: dead > score > jump.
- FSM states:
  - IDLE: if any pending bit is set, grant the highest-priority one on the next edge. Load half_period from that effect's start value, set active_id, clear the tick counter, go to PLAY. tone_en = ~mute.
  - PLAY: on each tick, increment the tick counter.
    - Jump: half_period -= JUMP_STEP, saturating at HP_MIN.
    - Dead: half_period += DEAD_STEP, saturating at 24'hFFFFFF.
    - Score: when the counter reaches SCORE_TICKS, load SCORE_HP2. At 2*SCORE_TICKS the effect ends.
    - Jump/dead end when the counter reaches JUMP_TICKS/DEAD_TICKS.
    - On end: tone_en=0, active_id=0, go to GAP.
  - GAP: silent for GAP_TICKS ticks, then go to IDLE. half_period holds its last value.
- Preemption: dead pending while jump or score is in PLAY or GAP grants death on the next edge, bypassing the gap. The preempted effect is dropped, not resumed. Score and jump never preempt.
- A dead_evt during death PLAY sets pending, and death replays after the gap. Jump and score behave the same for themselves.
- Simultaneous events: all pending bits are set and served in priority order, each followed by a gap.
- mute affects only tone_en; timing, active_id and busy are unaffected.
- Arithmetic: all half-period math is 24-bit unsigned, compared before the update so no wrap-around can occur.

Test Plan:
(Bench parameters: TICK_DIV=4, JUMP_TICKS=5, DEAD_TICKS=6, SCORE_TICKS=3, GAP_TICKS=2, JUMP_HP=1000, JUMP_STEP=100, HP_MIN=800.)
- jump_evt pulse -> next edge active_id=1, half_period=1000, tone_en=1. half_period then steps to 900, then 800, then holds at 800. After 5 ticks (20 clocks) tone_en=0; busy drops 2 ticks (8 clocks) later.
- score_evt -> half_period=SCORE_HP1 for 3 ticks, then SCORE_HP2 for 3 ticks, then tone_en=0 and active_id=0.
- jump_evt and dead_evt in the same cycle -> death plays first (active_id=3), then a 2-tick gap, then jump (active_id=1). Both pending bits end cleared.
- dead_evt at jump tick 2 -> next edge active_id=3, half_period=DEAD_HP. Jump does not resume afterward.
- mute=1 during score -> tone_en=0 throughout, while active_id and half_period follow the normal sequence.
- reset asserted mid-death (asynchronous, between edges) -> tone_en, busy, active_id and half_period go to 0 immediately. After release with no events the FSM stays in IDLE.
